// File: rtl/gb_bus_pkg.sv
// Shared bus constants for memory-side responders on the 8-bit OR bus.
// Holds register addresses, interrupt vector layout and the ack FSM encoding.
package gb_bus_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [15:0] INT_VECTOR_BASE   = 16'h0040;
  localparam int          INT_VECTOR_STRIDE = 8;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [0:0] ACK_IDLE = 1'b0;
  localparam logic [0:0] ACK_BUSY = 1'b1;

endpackage

// File: rtl/priority_encoder_lsb.sv
// Lowest-set-bit priority encoder: bit 0 wins.
// Purely combinational; valid is low when no input bit is set.
module priority_encoder_lsb #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register responder with lowest-index-first acknowledge and vectoring.
// Define INTC_EDGE_DETECT_EN for edge-triggered request capture (level otherwise).
module interrupt_controller
  import gb_bus_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = INT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = INT_VECTOR_STRIDE
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Enable,
  input  logic [15:0]        i_Address,
  input  logic               i_Address_Out,
  input  logic               i_Bus_Out,
  input  logic               i_Bus_In,
  input  logic [7:0]         i_Bus,
  output logic [7:0]         o_Bus,
  input  logic [NUM_IRQ-1:0] i_Requests,
  output logic [NUM_IRQ-1:0] o_Interrupts,
  input  logic               i_Handle_Interrupt,
  output logic [15:0]        o_Vector
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic [0:0]         state_q;

  logic               sel_if;
  logic               sel_ie;
  logic               wr_if;
  logic               wr_ie;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [NUM_IRQ-1:0] if_base;
  logic [IW-1:0]      idx;
  logic               idx_valid;
  logic               take_ack;
  logic [15:0]        vec_next;

  assign sel_if = i_Address_Out & (i_Address == ADDR_IF);
  assign sel_ie = i_Address_Out & (i_Address == ADDR_IE);
  assign wr_if  = sel_if & i_Bus_Out;
  assign wr_ie  = sel_ie & i_Bus_Out;

  assign pending      = if_q & ie_q[NUM_IRQ-1:0];
  assign o_Interrupts = pending;

  always_comb begin
    o_Bus = 8'h00;
    unique case (1'b1)
      sel_if & i_Bus_In: o_Bus = {{(8 - NUM_IRQ){1'b1}}, if_q};
      sel_ie & i_Bus_In: o_Bus = ie_q;
      default:           o_Bus = 8'h00;
    endcase
  end

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] req_prev;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      req_prev <= '0;
    end else if (i_Enable) begin
      req_prev <= i_Requests;
    end
  end

  assign rise = i_Requests & ~req_prev;
`else
  assign rise = i_Requests;
`endif

  priority_encoder_lsb #(
    .N  (NUM_IRQ),
    .IW (IW)
  ) u_prio (
    .req   (pending),
    .idx   (idx),
    .valid (idx_valid)
  );

  // Only the IDLE->ACK edge clears; a long strobe cannot eat more flags.
  assign take_ack  = (state_q == ACK_IDLE) & i_Handle_Interrupt;
  assign ack_clear = (take_ack & idx_valid)
                   ? (NUM_IRQ'(1) << idx) : '0;

  assign vec_next = idx_valid
                  ? VECTOR_BASE + 16'(VECTOR_STRIDE) * 16'(idx)
                  : 16'h0000;

  assign if_base = wr_if ? i_Bus[NUM_IRQ-1:0] : if_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      if_q     <= '0;
      ie_q     <= 8'h00;
      state_q  <= ACK_IDLE;
      o_Vector <= 16'h0000;
    end else if (i_Enable) begin
      if_q <= (if_base & ~ack_clear) | rise;
      if (wr_ie) ie_q <= i_Bus;
      unique case (state_q)
        ACK_IDLE: begin
          if (i_Handle_Interrupt) begin
            state_q  <= ACK_BUSY;
            o_Vector <= vec_next;
          end
        end
        ACK_BUSY: begin
          if (!i_Handle_Interrupt) state_q <= ACK_IDLE;
        end
        default: state_q <= ACK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_interrupt_controller;

  typedef enum logic [1:0] {K_BUS, K_INT, K_VEC} kind_t;

  typedef struct {
    kind_t       kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        aout = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic [4:0]  req = 5'h00;
  logic [4:0]  ints;
  logic        hdl = 1'b0;
  logic [15:0] vec;

  chk_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .i_Clk              (clk),
    .i_Rst_n            (rst_n),
    .i_Enable           (en),
    .i_Address          (addr),
    .i_Address_Out      (aout),
    .i_Bus_Out          (wr),
    .i_Bus_In           (rd),
    .i_Bus              (wdata),
    .o_Bus              (rdata),
    .i_Requests         (req),
    .o_Interrupts       (ints),
    .i_Handle_Interrupt (hdl),
    .o_Vector           (vec)
  );

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [15:0] act;
      c = sb.pop_front();
      case (c.kind)
        K_BUS:   act = {8'h00, rdata};
        K_INT:   act = {11'h000, ints};
        default: act = vec;
      endcase
      n_total++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s: got %h want %h", c.name, act, c.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(kind_t k, logic [15:0] e, string n);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = n;
    sb.push_back(c);
  endtask

  task automatic bus_wr(logic [15:0] a, logic [7:0] d);
    addr = a; aout = 1'b1; wr = 1'b1; wdata = d;
    tick();
    aout = 1'b0; wr = 1'b0;
  endtask

  task automatic exp_rd(logic [15:0] a, logic [7:0] e, string n);
    addr = a; aout = 1'b1; rd = 1'b1;
    push(K_BUS, {8'h00, e}, n);
    sample();
    aout = 1'b0; rd = 1'b0;
  endtask

  task automatic exp_out(kind_t k, logic [15:0] e, string n);
    push(k, e, n);
    sample();
  endtask

  initial begin
    tick(); tick();
    exp_rd(16'hFF0F, 8'hE0, "rst_if");
    exp_rd(16'hFFFF, 8'h00, "rst_ie");
    exp_out(K_INT, 16'h0000, "rst_int");
    exp_out(K_VEC, 16'h0000, "rst_vec");
    exp_rd(16'h1234, 8'h00, "unsel_rd");
    n_total++;
    if (ints === 5'h00 && vec === 16'h0000) n_pass++;
    else $display("FAIL rst_direct: ints %h vec %h", ints, vec);
    rst_n = 1'b1;
    tick();

    bus_wr(16'hFFFF, 8'h05);
    exp_rd(16'hFFFF, 8'h05, "ie_wr");
    @(posedge clk); #1;
    req = 5'b00101;
    tick();
    req = 5'h00;
    exp_rd(16'hFF0F, 8'hE5, "if_req");
    exp_out(K_INT, 16'h0005, "int_req");

    @(posedge clk); #1;
    hdl = 1'b1;
    tick();
    exp_out(K_VEC, 16'h0040, "ack0_vec");
    exp_rd(16'hFF0F, 8'hE4, "ack0_if");
    @(posedge clk); #1;
    exp_rd(16'hFF0F, 8'hE4, "ack_hold1");
    @(posedge clk); #1;
    exp_rd(16'hFF0F, 8'hE4, "ack_hold2");
    exp_out(K_VEC, 16'h0040, "ack_hold_vec");
    @(posedge clk); #1;
    hdl = 1'b0;
    tick();
    hdl = 1'b1;
    tick();
    hdl = 1'b0;
    exp_out(K_VEC, 16'h0050, "ack2_vec");
    exp_rd(16'hFF0F, 8'hE0, "ack2_if");
    exp_out(K_INT, 16'h0000, "ack2_int");
    tick();

    @(posedge clk); #1;
    req = 5'b00010;
    bus_wr(16'hFF0F, 8'h00);
    req = 5'h00;
    exp_rd(16'hFF0F, 8'hE2, "wr0_vs_req");
    exp_out(K_INT, 16'h0000, "masked_int");

    @(posedge clk); #1;
    hdl = 1'b1;
    tick();
    hdl = 1'b0;
    exp_out(K_VEC, 16'h0000, "ack_none_vec");
    exp_rd(16'hFF0F, 8'hE2, "ack_none_if");
    tick();

    @(posedge clk); #1;
    en = 1'b0;
    req = 5'b11001;
    hdl = 1'b1;
    bus_wr(16'hFFFF, 8'hFF);
    bus_wr(16'hFF0F, 8'h1F);
    tick();
    exp_rd(16'hFF0F, 8'hE2, "en_lo_if");
    exp_rd(16'hFFFF, 8'h05, "en_lo_ie");
    exp_out(K_VEC, 16'h0000, "en_lo_vec");
    req = 5'h00;
    hdl = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    tick();

    req = 5'b01000;
    tick(); tick(); tick(); tick();
    exp_rd(16'hFF0F, 8'hEA, "held_if");
    @(posedge clk); #1;
    bus_wr(16'hFF0F, 8'h00);
`ifdef INTC_EDGE_DETECT_EN
    exp_rd(16'hFF0F, 8'hE0, "held_wr0");
`else
    exp_rd(16'hFF0F, 8'hE8, "held_wr0");
`endif
    req = 5'h00;
    tick();

    bus_wr(16'hFFFF, 8'h1F);
    req = 5'b00001;
    tick();
    req = 5'h00;
    hdl = 1'b1;
    tick();
    exp_out(K_VEC, 16'h0040, "pre_rst_vec");
    rst_n = 1'b0;
    #1;
    exp_out(K_VEC, 16'h0000, "mid_rst_vec");
    exp_out(K_INT, 16'h0000, "mid_rst_int");
    exp_rd(16'hFF0F, 8'hE0, "mid_rst_if");
    exp_rd(16'hFFFF, 8'h00, "mid_rst_ie");
    n_total++;
    if (vec === 16'h0000) n_pass++;
    else $display("FAIL mid_rst_direct: vec %h", vec);
    hdl = 1'b0;
    rst_n = 1'b1;
    tick();

    bus_wr(16'hFFFF, 8'h10);
    req = 5'b10000;
    tick();
    req = 5'h00;
    hdl = 1'b1;
    tick();
    hdl = 1'b0;
    exp_out(K_VEC, 16'h0060, "post_rst_vec");
    exp_rd(16'hFF0F, 8'hE0, "post_rst_if");
    n_total++;
    if (ints === 5'h00) n_pass++;
    else $display("FAIL post_rst_int: ints %h", ints);
    tick();

    sample();
    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_pass == n_total) $display("PASS");
    else $display("FAIL %0d checks failed", n_total - n_pass);
    $finish;
  end

endmodule
